// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder/subtractor, LSB first, valid/ready in and out
// A DIGIT-bit ripple slice of full-adder cells is reused N = WIDTH/DIGIT times per operation.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder: DIGIT must divide WIDTH, 1 <= DIGIT <= WIDTH, WIDTH >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    count;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] d;
  logic [WIDTH-1:0] s_next;

  assign c[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_slice
    serial_adder_fa u_fa (
      .a  (a_sh[i]),
      .b  (b_sh[i]),
      .ci (c[i]),
      .s  (d[i]),
      .co (c[i+1])
    );
  end

  // New digit enters at the MSB end so the final shift leaves the result aligned.
  assign s_next = (s_sh >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
      carry     <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
            a_sh     <= a;
            b_sh     <= b ^ {WIDTH{sub}};
            carry    <= sub;
            count    <= '0;
            s_sh     <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          s_sh  <= s_next;
          carry <= c[DIGIT];
          count <= count + 1'b1;
          if (count == CW'(N - 1)) begin
            sum       <= s_next;
            cout      <= c[DIGIT];
            ovf       <= c[DIGIT-1] ^ c[DIGIT];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at DIGIT = 1, 4 and 8
module tb_serial_adder;
  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a [3];
  logic [7:0] b [3];
  logic       sub [3];
  logic       in_valid [3];
  logic       out_ready [3];
  logic       in_ready_w [3];
  logic       out_valid_w [3];
  logic [7:0] sum_w [3];
  logic       cout_w [3];
  logic       ovf_w [3];

  exp_t exp_q [3][$];
  logic seen [3];
  int   lat_n [3] = '{8, 2, 1};
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .a(a[0]), .b(b[0]), .sub(sub[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready[0]), .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .a(a[1]), .b(b[1]), .sub(sub[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready[1]), .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1]));
  serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .a(a[2]), .b(b[2]), .sub(sub[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready[2]), .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2]));

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  function automatic exp_t model(logic [7:0] av, logic [7:0] bv, logic sv);
    exp_t     e;
    logic [8:0] full;
    logic [7:0] bb;
    bb   = sv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bb} + {8'd0, sv};
    e.s  = full[7:0];
    e.c  = full[8];
    e.o  = (av[7] == bb[7]) && (full[7] != av[7]);
    e.acc = 0;
    return e;
  endfunction

  task automatic send(int i, logic [7:0] av, logic [7:0] bv, logic sv,
                      logic [7:0] es, logic ec, logic eo);
    int   w;
    exp_t e;
    w = 0;
    while (!in_ready_w[i] && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready_w[i]) begin
      chk($sformatf("in_ready_timeout%0d", i), 32'(in_ready_w[i]), 32'd1);
      return;
    end
    a[i] = av; b[i] = bv; sub[i] = sv; in_valid[i] = 1'b1;
    @(posedge clk); #1;
    e.s = es; e.c = ec; e.o = eo; e.acc = cyc;
    exp_q[i].push_back(e);
    in_valid[i] = 1'b0;
    a[i] = 8'hxx; b[i] = 8'hxx;
  endtask

  task automatic send_rand(int i);
    logic [7:0] av, bv;
    logic       sv;
    exp_t       e;
    av = 8'($urandom); bv = 8'($urandom); sv = 1'($urandom);
    e  = model(av, bv, sv);
    send(i, av, bv, sv, e.s, e.c, e.o);
  endtask

  // Latency is judged on the rising cycle of out_valid, values on the handoff cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid_w[i] && !seen[i]) begin
          seen[i] = 1'b1;
          if (exp_q[i].size() == 0) chk($sformatf("spurious_valid%0d", i), 32'd1, 32'd0);
          else chk($sformatf("latency%0d", i), 32'(cyc - exp_q[i][0].acc), 32'(lat_n[i]));
        end
        if (out_valid_w[i] && out_ready[i] && exp_q[i].size() != 0) begin
          exp_t e;
          e = exp_q[i].pop_front();
          chk($sformatf("sum%0d", i),  32'(sum_w[i]),  32'(e.s));
          chk($sformatf("cout%0d", i), 32'(cout_w[i]), 32'(e.c));
          chk($sformatf("ovf%0d", i),  32'(ovf_w[i]),  32'(e.o));
          seen[i] = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 32'd0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 3; i++) begin
      a[i] = 8'h00; b[i] = 8'h00; sub[i] = 1'b0;
      in_valid[i] = 1'b0; out_ready[i] = 1'b1; seen[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready%0d", i),  32'(in_ready_w[i]),  32'd1);
      chk($sformatf("rst_out_valid%0d", i), 32'(out_valid_w[i]), 32'd0);
      chk($sformatf("rst_sum%0d", i),       32'(sum_w[i]),       32'd0);
    end
    chk("rst_cout", 32'(cout_w[0]), 32'd0);
    chk("rst_ovf",  32'(ovf_w[0]),  32'd0);

    // 0x0F + 0x01 held under backpressure for 5 cycles
    out_ready[0] = 1'b0;
    send(0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    w = 0;
    while (!out_valid_w[0] && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 32'(out_valid_w[0]), 32'd1);
      chk("bp_in_ready",  32'(in_ready_w[0]),  32'd0);
      chk("bp_sum",       32'(sum_w[0]),       32'h10);
      chk("bp_cout_ovf",  32'({cout_w[0], ovf_w[0]}), 32'd0);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", 32'(in_ready_w[0]), 32'd1);
    chk("bp_out_valid_after", 32'(out_valid_w[0]), 32'd0);
    chk("bp_sum_kept", 32'(sum_w[0]), 32'h10);

    send(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    send(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    send(0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    send(0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    wait_drain();

    // Abort mid-RUN at count 3
    send(0, 8'h10, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid_w[0]), 32'd0);
    chk("abort_sum",       32'(sum_w[0]),       32'd0);
    chk("abort_cout_ovf",  32'({cout_w[0], ovf_w[0]}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      seen[i] = 1'b0;
    end
    @(posedge clk); #1 rst = 1'b0;
    send(0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    wait_drain();

    send(1, 8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0);
    send(2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    send(2, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) send_rand(i);
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
